// File: rtl/add_result_streamer_pkg.sv
// Shared types and sizing helpers for the wide-result-to-lane streamer.
package add_stream_pkg;

    localparam int DEF_LANES      = 16;
    localparam int DEF_LANE_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Checksum width large enough that summing every lane at full scale cannot overflow.
    function automatic int acc_width(input int lanes, input int lane_width);
        return lane_width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/add_result_streamer_if.sv
// Wide-vector input handshake, narrow lane output handshake and frame status.
interface add_stream_if
    import add_stream_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

    localparam int ACC_WIDTH = acc_width(LANES, LANE_WIDTH);
    localparam int IDX_WIDTH = $clog2(LANES);

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*LANE_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANE_WIDTH-1:0]       out_data;
    logic [IDX_WIDTH-1:0]        out_lane;
    logic                        out_last;
    logic [ACC_WIDTH-1:0]        frame_sum;
    logic                        frame_done;
    logic [CNT_WIDTH-1:0]        frame_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last,
               frame_sum, frame_done, frame_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last,
               frame_sum, frame_done, frame_count
    );

endinterface

// File: rtl/add_result_streamer_lane_mux.sv
// Frame buffer that snapshots the whole wide vector on load and presents one lane by index.
module lane_mux #(
    parameter int LANES      = 16,
    parameter int LANE_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [LANES*LANE_WIDTH-1:0] data,
    input  logic [$clog2(LANES)-1:0]    sel,
    output logic [LANE_WIDTH-1:0]       lane
);

    logic [LANE_WIDTH-1:0] buf_q [LANES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) buf_q[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < LANES; k++) buf_q[k] <= data[k*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    assign lane = buf_q[sel];

endmodule

// File: rtl/add_result_streamer.sv
// Captures one wide adder result, streams its lanes one per handshake, and reports
// a per-frame checksum plus a running frame count.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a wide vector
// STREAM | presenting lane[idx], advancing on each accepted lane
// FINISH | one-cycle frame_done pulse, frame_sum/frame_count just updated
module add_result_streamer
    import add_stream_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic        clk,
    input  logic        reset_n,
    add_stream_if.slave bus
);

    localparam int ACC_WIDTH = acc_width(LANES, LANE_WIDTH);
    localparam int IDX_WIDTH = $clog2(LANES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LANES - 1);

    state_t                state, state_nx;
    logic [IDX_WIDTH-1:0]  idx;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_nx;
    logic [ACC_WIDTH-1:0]  frame_sum_q;
    logic [CNT_WIDTH-1:0]  frame_count_q;
    logic [LANE_WIDTH-1:0] lane;
    logic                  capture;
    logic                  take;
    logic                  is_last;
    logic                  streaming;

    assign streaming = (state == STREAM);
    assign capture   = (state == IDLE) && bus.in_valid;
    assign take      = streaming && bus.out_ready;
    assign is_last   = (idx == LAST_IDX);
    assign acc_nx    = acc + {{(ACC_WIDTH-LANE_WIDTH){1'b0}}, lane};

    lane_mux #(
        .LANES      (LANES),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_lane_mux (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (capture),
        .data    (bus.in_data),
        .sel     (idx),
        .lane    (lane)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = STREAM;
            STREAM:  if (bus.out_ready && is_last) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The checksum and count commit on the last acceptance so they are already
    // valid during the FINISH cycle that carries frame_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx           <= '0;
            acc           <= '0;
            frame_sum_q   <= '0;
            frame_count_q <= '0;
        end else if (capture) begin
            idx <= '0;
            acc <= '0;
        end else if (take) begin
            acc <= acc_nx;
            if (is_last) begin
                frame_sum_q   <= acc_nx;
                frame_count_q <= frame_count_q + 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = streaming;
    assign bus.out_data    = streaming ? lane : '0;
    assign bus.out_lane    = streaming ? idx : '0;
    assign bus.out_last    = streaming && is_last;
    assign bus.frame_sum   = frame_sum_q;
    assign bus.frame_done  = (state == FINISH);
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_add_result_streamer.sv
// Directed bench for add_result_streamer; a narrow-counter second instance covers counter wrap.
module tb_add_result_streamer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_stream_if #(.LANES(16), .LANE_WIDTH(16), .CNT_WIDTH(16)) bus ();
    add_stream_if #(.LANES(16), .LANE_WIDTH(16), .CNT_WIDTH(4))  bus_w ();

    add_result_streamer #(.LANES(16), .LANE_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    add_result_streamer #(.LANES(16), .LANE_WIDTH(16), .CNT_WIDTH(4)) dut_w (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    function automatic logic [255:0] mk(input int base, input int step);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(base + step*k);
        return r;
    endfunction

    task automatic offer(input logic [255:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL offer_timeout in_ready=%b required 1", bus.in_ready);
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [59:0] obs;
        logic [59:0] exp_v;
        exp_v = {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 20'h0, 1'b0, 16'h0};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_lane, bus.out_last,
                   bus.frame_sum, bus.frame_done, bus.frame_count};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_idle cycle=%0d got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_incrementing();
        int t0;
        bus.out_ready = 1'b1;
        offer(mk(1, 1));
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(k + 1) || bus.out_lane !== 4'(k)) begin
                tests_failed++;
                $display("FAIL inc_lane k=%0d got v=%b d=%h l=%0d want v=1 d=%h l=%0d",
                         k, bus.out_valid, bus.out_data, bus.out_lane, 16'(k + 1), k);
            end
            tests_run++;
            if (bus.out_last !== (k == 15)) begin
                tests_failed++;
                $display("FAIL inc_last k=%0d got %b want %b", k, bus.out_last, (k == 15));
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.frame_done !== 1'b1 || (cyc - t0) != 17) begin
            tests_failed++;
            $display("FAIL inc_done_time got done=%b at +%0d want done=1 at +17", bus.frame_done, cyc - t0);
        end
        tests_run++;
        if (bus.frame_sum !== 20'd136 || bus.frame_count !== 16'd1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL inc_sum got sum=%0d cnt=%0d v=%b want sum=136 cnt=1 v=0",
                     bus.frame_sum, bus.frame_count, bus.out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.frame_done !== 1'b0 || bus.frame_sum !== 20'd136) begin
            tests_failed++;
            $display("FAIL inc_after got rdy=%b done=%b sum=%0d want rdy=1 done=0 sum=136",
                     bus.in_ready, bus.frame_done, bus.frame_sum);
        end
    endtask

    task automatic test_all_ones();
        bus.out_ready = 1'b1;
        offer(mk(16'hFFFF, 0));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (bus.frame_done !== 1'b1 || bus.frame_sum !== 20'hFFFF0 || bus.frame_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL ones_sum got done=%b sum=%h cnt=%0d want done=1 sum=ffff0 cnt=2",
                     bus.frame_done, bus.frame_sum, bus.frame_count);
        end
    endtask

    task automatic test_stalls();
        logic [15:0]  lanes [16];
        logic [19:0]  model;
        logic [255:0] d;
        int           got;
        int           n;
        bit           r;
        model = '0;
        for (int k = 0; k < 16; k++) begin
            lanes[k] = 16'(k*4099 + 7);
            d[k*16 +: 16] = lanes[k];
            model = model + 20'(lanes[k]);
        end
        bus.out_ready = 1'b0;
        offer(d);
        got = 0;
        n = 0;
        while (got < 16 && n < 200) begin
            @(negedge clk);
            n++;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== lanes[got] || bus.out_lane !== 4'(got)) begin
                tests_failed++;
                $display("FAIL stall_lane n=%0d got v=%b d=%h l=%0d want v=1 d=%h l=%0d",
                         n, bus.out_valid, bus.out_data, bus.out_lane, lanes[got], got);
            end
            tests_run++;
            if (bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_in_ready n=%0d got %b want 0", n, bus.in_ready);
            end
            r = 1'($urandom_range(0, 1));
            bus.out_ready = r;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
            if (r) got++;
        end
        tests_run++;
        if (got != 16) begin
            tests_failed++;
            $display("FAIL stall_timeout got %0d lanes want 16", got);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.frame_done !== 1'b1 || bus.frame_sum !== model || bus.frame_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL stall_sum got done=%b sum=%h cnt=%0d want done=1 sum=%h cnt=3",
                     bus.frame_done, bus.frame_sum, bus.frame_count, model);
        end
    endtask

    task automatic test_reset_mid();
        logic [59:0] obs;
        logic [59:0] exp_v;
        exp_v = {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 20'h0, 1'b0, 16'h0};
        bus.out_ready = 1'b1;
        offer(mk(256, 1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_lane, bus.out_last,
               bus.frame_sum, bus.frame_done, bus.frame_count};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL midreset_outputs got %h want %h", obs, exp_v);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.frame_done !== 1'b0 || bus.frame_count !== 16'd0) begin
                tests_failed++;
                $display("FAIL midreset_hold c=%0d got done=%b cnt=%0d want done=0 cnt=0",
                         c, bus.frame_done, bus.frame_count);
            end
        end
        reset_n = 1'b1;
        offer(mk(32, 1));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            tests_run++;
            if (bus.out_data !== 16'(32 + k) || bus.out_lane !== 4'(k) || bus.frame_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_lane k=%0d got d=%h l=%0d done=%b want d=%h l=%0d done=0",
                         k, bus.out_data, bus.out_lane, bus.frame_done, 16'(32 + k), k);
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.frame_done !== 1'b1 || bus.frame_sum !== 20'd632 || bus.frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL midreset_sum got done=%b sum=%0d cnt=%0d want done=1 sum=632 cnt=1",
                     bus.frame_done, bus.frame_sum, bus.frame_count);
        end
    endtask

    task automatic test_back_to_back();
        int nf;
        int last;
        int n;
        nf = 0;
        last = 0;
        n = 0;
        bus_w.out_ready = 1'b1;
        bus_w.in_data   = mk(1, 0);
        @(negedge clk);
        bus_w.in_valid = 1'b1;
        while (nf < 17 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus_w.frame_done === 1'b1) begin
                nf++;
                tests_run++;
                if (bus_w.frame_count !== 4'(nf) || bus_w.frame_sum !== 20'd16) begin
                    tests_failed++;
                    $display("FAIL b2b_frame f=%0d got cnt=%0d sum=%0d want cnt=%0d sum=16",
                             nf, bus_w.frame_count, bus_w.frame_sum, 4'(nf));
                end
                if (nf > 1) begin
                    tests_run++;
                    if (cyc - last != 18) begin
                        tests_failed++;
                        $display("FAIL b2b_period f=%0d got %0d want 18", nf, cyc - last);
                    end
                end
                last = cyc;
            end
        end
        bus_w.in_valid = 1'b0;
        tests_run++;
        if (nf != 17 || bus_w.frame_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL b2b_wrap got frames=%0d cnt=%0d want frames=17 cnt=1", nf, bus_w.frame_count);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_data   = '0;
        bus_w.out_ready = 1'b0;
        test_reset();
        test_incrementing();
        test_all_ones();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_result_streamer.md
# add_result_streamer

Downstream stage of the 16-lane ROM-fed adder. It captures one wide result vector from `matrix_add_16` (16 lanes × 16 bits) through a valid/ready handshake. It then streams the lanes out one per handshake, keeps a frame checksum (sum of all lanes), and counts completed frames. It turns the parallel adder output into a narrow stream that a UART/debug port or a result checker can consume.

## Interface
- `LANES`, 16, number of result lanes per frame (power of two, ≥2)
- `LANE_WIDTH`, 16, bits per lane
- `ACC_WIDTH`, `LANE_WIDTH+$clog2(LANES)` (20), frame checksum width
- `CNT_WIDTH`, 16, frame counter width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  wide result vector available
- `in_ready`  out  1  block can accept a vector
- `in_data`  in  `LANES*LANE_WIDTH`  lane k = `in_data[k*LANE_WIDTH +: LANE_WIDTH]`
- `out_valid`  out  1  `out_data` holds a lane
- `out_ready`  in  1  consumer accepts the lane
- `out_data`  out  `LANE_WIDTH`  current lane value
- `out_lane`  out  `$clog2(LANES)`  index of current lane
- `out_last`  out  1  current lane is lane `LANES-1`
- `frame_sum`  out  `ACC_WIDTH`  unsigned sum of all lanes of the last completed frame
- `frame_done`  out  1  one-cycle pulse; `frame_sum` updated that cycle
- `frame_count`  out  `CNT_WIDTH`  completed frames since reset

## Operation
- FSM states:
  - **IDLE**:
    - `in_ready`=1 and `out_valid`=0.
    - When `in_valid` is high, latch `in_data` into the frame buffer, clear the lane index and accumulator, and go to STREAM.
  - **STREAM**:
    - `out_valid`=1, `out_data` = buffer lane[idx], `out_lane`=idx, `out_last`=(idx==LANES-1).
    - On `out_valid && out_ready`: acc += zero-extended lane. If not last, idx++. If last, go to FINISH.
  - **FINISH** (one cycle):
    - `frame_sum` ← final acc (includes the last lane).
    - `frame_done`=1 and `frame_count`++ (wraps modulo 2^CNT_WIDTH).
    - Go to IDLE.
- `in_ready` is high only in IDLE. `in_data` is ignored in all other states.
- While stalled (`out_ready`=0), `out_data`, `out_lane` and `out_last` hold stable and `out_valid` stays high. It is never withdrawn before acceptance.
- Arithmetic:
  - Lanes are unsigned. The accumulator is `ACC_WIDTH` bits and cannot overflow: max is LANES×(2^LANE_WIDTH−1) < 2^ACC_WIDTH.
  - `frame_sum` holds its value until the next FINISH.
- Reset (asynchronous, any state):
  - Go to IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0.
  - `frame_sum`=0, `frame_done`=0, `frame_count`=0.
  - The buffer and accumulator are cleared.
  - A frame in progress is discarded, is not counted and produces no `frame_done`.

## Timing
- Input accepted at edge N. The first `out_valid` is seen in cycle N+1, with lane 0.
- With `out_ready` held high, lane k is accepted at edge N+1+k. The last lane is accepted at edge N+LANES.
- FINISH occupies the cycle after the last acceptance: `frame_done` is high in cycle N+LANES+1. `frame_sum` and `frame_count` change at that same edge.
- `in_ready` rises in cycle N+LANES+2. Minimum frame period is LANES+2 = 18 cycles.
- The upstream ROM/adder produces a new vector every cycle. Vectors offered while `in_ready`=0 are dropped by upstream design intent (it is a free-running demo). The block must not capture them.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `add_stream_pkg`:
  - state enum `{IDLE, STREAM, FINISH}`
  - default `LANES` and `LANE_WIDTH` constants
  - `ACC_WIDTH` function
- Optional sub-module `lane_mux`: registered-buffer lane selector, parameterised by `LANES`/`LANE_WIDTH`. The rest stays in one module.

## Test plan
- Reset release, no stimulus:
  - all outputs at reset values, `in_ready`=1, `frame_count`=0 for 50 cycles.
- Lanes k = k+1 (1..16), `out_ready` held 1:
  - `out_data` sequence 1..16, `out_last` only on the 16th.
  - `frame_done` at N+17.
  - `frame_sum`=136, `frame_count`=1.
- All lanes 0xFFFF:
  - `frame_sum`=0xFFFF0 (1048560), no overflow.
- Random `out_ready` stalls (50%):
  - data/lane stable during stalls, 16 accepted lanes in order.
  - `frame_sum` matches the model.
  - `in_valid` pulses during STREAM are ignored.
- Assert `reset_n` low after lane 7 is accepted:
  - outputs reset immediately.
  - `frame_count` stays 0 and no `frame_done`.
  - the next frame streams correctly from lane 0.
- 65537 back-to-back frames:
  - `frame_count` wraps to 1.
  - period is exactly 18 cycles with `out_ready`=1.
